// File: rtl/aesl_deadlock_reporter.sv
// aesl_deadlock_reporter: debounces the monitor's block signal, confirms a deadlock after CONFIRM_CYCLES
// consecutive blocked cycles and hands a one-shot report (onset stamp + snapshots) over valid/ready.
module aesl_deadlock_reporter #(
    parameter int CONFIRM_CYCLES = 16,
    parameter int CYC_W          = 32,
    parameter int N_AXIS         = 4,
    parameter int FA_W           = 8
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              enable_i,
    input  logic              block_i,
    input  logic [N_AXIS-1:0] axis_block_sigs_i,
    input  logic [N_AXIS-1:0] inst_idle_sigs_i,
    input  logic              clear_i,
    input  logic              report_ready_i,
    output logic              report_valid_o,
    output logic [CYC_W-1:0]  report_cycle_o,
    output logic [N_AXIS-1:0] report_axis_o,
    output logic [N_AXIS-1:0] report_idle_o,
    output logic              deadlock_found_o,
    output logic [FA_W-1:0]   false_alarms_o
);
    localparam int CNT_W = $clog2(CONFIRM_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, SUSPECT, CONFIRMED, REPORTED} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CYC_W-1:0]    cyc_q, t0_q, t0_d, rep_cycle_q, rep_cycle_d;
    logic [N_AXIS-1:0]   rep_axis_q, rep_axis_d, rep_idle_q, rep_idle_d;
    logic                found_q, found_d;
    logic [FA_W-1:0]     fa_q, fa_d;
    logic                blk, confirm;
    logic [CYC_W-1:0]    stamp;

    assign blk = block_i & enable_i;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        t0_d        = t0_q;
        rep_cycle_d = rep_cycle_q;
        rep_axis_d  = rep_axis_q;
        rep_idle_d  = rep_idle_q;
        found_d     = found_q;
        fa_d        = fa_q;
        confirm     = 1'b0;
        stamp       = t0_q;
        if (clear_i) begin
            state_d = IDLE;
            cnt_d   = '0;
            found_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: if (blk) begin
                    t0_d = cyc_q;
                    if (CONFIRM_CYCLES == 1) begin
                        confirm = 1'b1;
                        stamp   = cyc_q;
                    end else begin
                        state_d = SUSPECT;
                        cnt_d   = CNT_W'(1);
                    end
                end
                SUSPECT: begin
                    if (!blk) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        fa_d    = fa_q + ((&fa_q) ? FA_W'(0) : FA_W'(1));
                    end else if (cnt_q == CNT_W'(CONFIRM_CYCLES - 1)) begin
                        confirm = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                CONFIRMED: if (report_ready_i) state_d = REPORTED;
                default: state_d = state_q;
            endcase
            // Snapshots are taken on the confirming edge itself, not at stall onset.
            if (confirm) begin
                state_d     = CONFIRMED;
                cnt_d       = '0;
                rep_cycle_d = stamp;
                rep_axis_d  = axis_block_sigs_i;
                rep_idle_d  = inst_idle_sigs_i;
                found_d     = 1'b1;
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cyc_q       <= '0;
            t0_q        <= '0;
            rep_cycle_q <= '0;
            rep_axis_q  <= '0;
            rep_idle_q  <= '0;
            found_q     <= 1'b0;
            fa_q        <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cyc_q       <= (&cyc_q) ? cyc_q : cyc_q + CYC_W'(1);
            t0_q        <= t0_d;
            rep_cycle_q <= rep_cycle_d;
            rep_axis_q  <= rep_axis_d;
            rep_idle_q  <= rep_idle_d;
            found_q     <= found_d;
            fa_q        <= fa_d;
        end
    end

    assign report_valid_o   = (state_q == CONFIRMED);
    assign report_cycle_o   = rep_cycle_q;
    assign report_axis_o    = rep_axis_q;
    assign report_idle_o    = rep_idle_q;
    assign deadlock_found_o = found_q;
    assign false_alarms_o   = fa_q;
endmodule
